axi_rd_mux: RTL

- N-port AXI4 read master that generalises the single-requester instruction-fetch AXI interface.
- Front-end clients (IFU, LSU, later DMA/PTW) issue simple read requests with burst length and size.
- Round-robin arbitration; one AR per grant with ARID = client index; R beats are routed back by RID.
- Sits between the pipeline front/back ends and the single external AXI read port of top.

---
 rtl/axi_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 26 ++
 rtl/axi_rd_mux.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI encodings and the read-request record used by the read mux (and later the write side).
package axi_pkg;

    localparam int AXI_MAX_AW = 64;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [AXI_MAX_AW-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
    } ar_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr_i, wrapping around.
// Kept free of AXI specifics so the write channel can reuse it.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic          valid_o
);

    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!valid_o && (i == (int'(ptr_i) + k) % N) && req_i[i]) begin
                    grant_o[i] = 1'b1;
                    valid_o    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/axi_rd_mux.sv
// N-port AXI4 read master: round-robin AR issue with ARID = client index, R beats routed back by RID.
// Define AXI_RD_MUX_TIMEOUT_EN to add per-port read timeouts with stale-ID tracking.
module axi_rd_mux
    import axi_pkg::*;
#(
    parameter int NUM_PORTS   = 2,
    parameter int AW          = 64,
    parameter int DW          = 64,
    parameter int IDW         = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NUM_PORTS-1:0]    req_valid,
    output logic [NUM_PORTS-1:0]    req_ready,
    input  logic [NUM_PORTS*AW-1:0] req_addr,
    input  logic [NUM_PORTS*8-1:0]  req_len,
    input  logic [NUM_PORTS*3-1:0]  req_size,
    output logic [NUM_PORTS-1:0]    resp_valid,
    output logic [DW-1:0]           resp_data,
    output logic                    resp_last,
    output logic [1:0]              resp_resp,
    output logic                    unexp_rid,
    output logic [IDW-1:0]          ARID,
    output logic [AW-1:0]           ARADDR,
    output logic [7:0]              ARLEN,
    output logic [2:0]              ARSIZE,
    output logic [1:0]              ARBURST,
    output logic                    ARVALID,
    input  logic                    ARREADY,
    input  logic [IDW-1:0]          RID,
    input  logic [DW-1:0]           RDATA,
    input  logic [1:0]              RRESP,
    input  logic                    RLAST,
    input  logic                    RVALID,
    output logic                    RREADY
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0] busy_q, busy_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    ar_req_t              ar_q, ar_d;
    logic [IDW-1:0]       ar_id_q, ar_id_d;
    logic [1:0]           ar_burst_q, ar_burst_d;
    logic                 arvalid_q, arvalid_d;
    logic                 rready_q;
    logic [NUM_PORTS-1:0] resp_valid_q, resp_valid_d;
    logic [DW-1:0]        resp_data_q, resp_data_d;
    logic                 resp_last_q, resp_last_d;
    logic [1:0]           resp_resp_q, resp_resp_d;
    logic                 unexp_q, unexp_d;

    logic [NUM_PORTS-1:0] eligible, grant, rid_hit, stale;
    logic                 gnt_valid, beat_fire, rid_ok, rid_stale;

`ifdef AXI_RD_MUX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [NUM_PORTS-1:0] stale_q, stale_d;
    logic [CW-1:0]        cnt_q [NUM_PORTS];
    logic [CW-1:0]        cnt_d [NUM_PORTS];
    logic                 to_done;
    assign stale = stale_q;
`else
    assign stale = '0;
`endif

    // A new grant is allowed only when the AR stage is empty or emptying this cycle.
    assign eligible = (rready_q && (!arvalid_q || ARREADY)) ? (req_valid & ~busy_q & ~stale) : '0;

    rr_arbiter #(
        .N  (NUM_PORTS),
        .PW (PW)
    ) u_arb (
        .req_i   (eligible),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .valid_o (gnt_valid)
    );

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            rid_hit[i] = (RID == IDW'(i));
        end
    end

    assign beat_fire = RVALID && rready_q;
    assign rid_ok    = beat_fire && |(rid_hit & busy_q);
    assign rid_stale = beat_fire && |(rid_hit & stale);

    always_comb begin
        ar_d       = ar_q;
        ar_id_d    = ar_id_q;
        ar_burst_d = ar_burst_q;
        rr_ptr_d   = rr_ptr_q;
        arvalid_d  = arvalid_q && !ARREADY;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (gnt_valid && grant[i]) begin
                arvalid_d         = 1'b1;
                ar_id_d           = IDW'(i);
                ar_burst_d        = BURST_INCR;
                rr_ptr_d          = PW'((i + 1) % NUM_PORTS);
                ar_d.addr         = '0;
                ar_d.addr[AW-1:0] = req_addr[i*AW +: AW];
                ar_d.len          = req_len[i*8 +: 8];
                ar_d.size         = req_size[i*3 +: 3];
            end
        end
    end

    // Response routing; RLAST frees the port at the same edge the beat is forwarded.
    always_comb begin
        busy_d       = busy_q;
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        resp_last_d  = 1'b0;
        resp_resp_d  = resp_resp_q;
        unexp_d      = unexp_q;
        if (gnt_valid) begin
            busy_d = busy_q | grant;
        end
        if (rid_ok) begin
            resp_valid_d = rid_hit;
            resp_data_d  = RDATA;
            resp_last_d  = RLAST;
            resp_resp_d  = RRESP;
            if (RLAST) begin
                busy_d = busy_d & ~rid_hit;
            end
        end else if (beat_fire && !rid_stale) begin
            unexp_d = 1'b1;
        end
`ifdef AXI_RD_MUX_TIMEOUT_EN
        stale_d = stale_q;
        to_done = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (busy_q[i] && !(arvalid_q && ar_id_q == IDW'(i)) && cnt_q[i] != CW'(TIMEOUT_CYC)) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
            if (arvalid_q && ARREADY && ar_id_q == IDW'(i)) begin
                cnt_d[i] = '0;
            end
            // A real beat owns the response bus this cycle; a pending timeout waits one cycle.
            if (!rid_ok && !to_done && busy_q[i] && cnt_q[i] == CW'(TIMEOUT_CYC)) begin
                to_done         = 1'b1;
                resp_valid_d    = '0;
                resp_valid_d[i] = 1'b1;
                resp_last_d     = 1'b1;
                resp_resp_d     = RESP_SLVERR;
                resp_data_d     = '0;
                busy_d[i]       = 1'b0;
                stale_d[i]      = 1'b1;
            end
            if (rid_stale && RLAST && rid_hit[i]) begin
                stale_d[i] = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_q       <= '0;
            rr_ptr_q     <= '0;
            ar_q         <= '0;
            ar_id_q      <= '0;
            ar_burst_q   <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_last_q  <= 1'b0;
            resp_resp_q  <= RESP_OKAY;
            unexp_q      <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            rr_ptr_q     <= rr_ptr_d;
            ar_q         <= ar_d;
            ar_id_q      <= ar_id_d;
            ar_burst_q   <= ar_burst_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= 1'b1;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_last_q  <= resp_last_d;
            resp_resp_q  <= resp_resp_d;
            unexp_q      <= unexp_d;
        end
    end

`ifdef AXI_RD_MUX_TIMEOUT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stale_q <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stale_q <= stale_d;
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`endif

    assign req_ready  = grant;
    assign ARVALID    = arvalid_q;
    assign ARID       = ar_id_q;
    assign ARADDR     = ar_q.addr[AW-1:0];
    assign ARLEN      = ar_q.len;
    assign ARSIZE     = ar_q.size;
    assign ARBURST    = ar_burst_q;
    assign RREADY     = rready_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_last  = resp_last_q;
    assign resp_resp  = resp_resp_q;
    assign unexp_rid  = unexp_q;

endmodule
